// File: rtl/ds18b20_pkg.sv
// Shared types and constants for the DS18B20 one-wire master.
// All bus timing constants are in microseconds (ticks).
package ds18b20_pkg;

    typedef enum logic [2:0] {
        ST_INIT      = 3'd0,
        ST_WR_BYTE   = 3'd1,
        ST_CONV_WAIT = 3'd2,
        ST_RD_BYTE   = 3'd3,
        ST_UPDATE    = 3'd4
    } state_e;

    localparam logic [7:0] CMD_SKIP_ROM = 8'hCC;
    localparam logic [7:0] CMD_CONVERT  = 8'h44;
    localparam logic [7:0] CMD_READ     = 8'hBE;

    localparam int T_INIT_LOW    = 500;
    localparam int T_PRES_SAMPLE = 570;
    localparam int T_INIT_SLOT   = 1000;
    localparam int T_SLOT        = 64;
    localparam int T_WR0_LOW     = 60;
    localparam int T_RD_SAMPLE   = 13;
    localparam int T_SLOT_LOW    = 2;

    localparam logic [5:0] POINT_MDEG = 6'b001000;

    // Byte 0 of every command pair is skip-ROM; byte 1 depends on the phase.
    function automatic logic [7:0] cmd_byte(input logic phase, input logic byte_idx);
        return byte_idx ? (phase ? CMD_READ : CMD_CONVERT) : CMD_SKIP_ROM;
    endfunction

endpackage

// File: rtl/ds18b20_temp_fmt.sv
// Converts a DS18B20 two's-complement 1/16 degC reading into a
// sign flag and a magnitude in millidegrees (x125 >> 1).
module ds18b20_temp_fmt
    import ds18b20_pkg::*;
(
    input  logic [15:0] raw_i,
    output logic [19:0] mdeg_o,
    output logic        neg_o
);
    logic [10:0] mag;
    logic [19:0] prod;
    logic        unused_hi;

    assign neg_o = raw_i[15];
    // Bits 14:11 only repeat the sign for in-range readings.
    assign mag       = neg_o ? (~raw_i[10:0] + 11'd1) : raw_i[10:0];
    assign prod      = {9'd0, mag} * 20'd125;
    assign mdeg_o    = prod >> 1;
    assign unused_hi = ^raw_i[14:11];

endmodule

// File: rtl/ds18b20_ctrl.sv
// DS18B20 one-wire master: convert, wait, read scratchpad, publish
// the temperature in millidegrees for the seven-segment driver.
module ds18b20_ctrl
    import ds18b20_pkg::*;
#(
    parameter int CLK_DIV = 50,
    parameter int CONV_US = 750_000
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    inout  wire         dq,
    output logic [19:0] data,
    output logic [5:0]  point,
    output logic        sign,
    output logic        seg_en,
    output logic        error,
    output logic [2:0]  dbg_state_o
);
    localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int US_MAX = (CONV_US > T_INIT_SLOT) ? CONV_US : T_INIT_SLOT;
    localparam int US_W   = $clog2(US_MAX + 1);

    state_e            state_q, state_d;
    logic [DIV_W-1:0]  cnt_div_q, cnt_div_d;
    logic [US_W-1:0]   cnt_us_q, cnt_us_d;
    logic              phase_q, phase_d;
    logic              byte_idx_q, byte_idx_d;
    logic [2:0]        bit_idx_q, bit_idx_d;
    logic              run_q, run_d;
    logic              pres_q, pres_d;
    logic              dq_oe_q, dq_oe_d;
    logic              dq_s1_q, dq_s2_q;
    logic [15:0]       temp_raw_q, temp_raw_d;
    logic [19:0]       data_q, data_d;
    logic [5:0]        point_q, point_d;
    logic              sign_q, sign_d;
    logic              seg_en_q, seg_en_d;
    logic              error_q, error_d;

    logic              tick;
    logic              slot_last;
    logic [7:0]        cmd_d;
    logic              wr_bit;
    logic [19:0]       fmt_mdeg;
    logic              fmt_neg;

    ds18b20_temp_fmt u_fmt (
        .raw_i  (temp_raw_q),
        .mdeg_o (fmt_mdeg),
        .neg_o  (fmt_neg)
    );

    assign tick      = (cnt_div_q == DIV_W'(CLK_DIV - 1));
    assign cnt_div_d = tick ? '0 : cnt_div_q + DIV_W'(1);
    assign slot_last = (cnt_us_q == US_W'(T_SLOT - 1));

    // Open drain: only ever pull low or release.
    assign dq          = dq_oe_q ? 1'b0 : 1'bz;
    assign data        = data_q;
    assign point       = point_q;
    assign sign        = sign_q;
    assign seg_en      = seg_en_q;
    assign error       = error_q;
    assign dbg_state_o = state_q;

    always_comb begin
        state_d    = state_q;
        cnt_us_d   = cnt_us_q;
        phase_d    = phase_q;
        byte_idx_d = byte_idx_q;
        bit_idx_d  = bit_idx_q;
        run_d      = run_q;
        pres_d     = pres_q;
        dq_oe_d    = dq_oe_q;
        temp_raw_d = temp_raw_q;
        data_d     = data_q;
        point_d    = point_q;
        sign_d     = sign_q;
        seg_en_d   = seg_en_q;
        error_d    = error_q;
        cmd_d      = 8'd0;
        wr_bit     = 1'b0;

        if (state_q == ST_UPDATE) begin
            data_d     = fmt_mdeg;
            sign_d     = fmt_neg;
            point_d    = POINT_MDEG;
            seg_en_d   = 1'b1;
            state_d    = ST_INIT;
            phase_d    = 1'b0;
            cnt_us_d   = '0;
            byte_idx_d = 1'b0;
            bit_idx_d  = 3'd0;
            // The next INIT waits for a tick so its slot is aligned.
            run_d      = 1'b0;
        end else if (tick) begin
            if (!run_q) begin
                run_d = 1'b1;
            end else begin
                cnt_us_d = cnt_us_q + US_W'(1);
                case (state_q)
                    ST_INIT: begin
                        if (cnt_us_q == US_W'(T_PRES_SAMPLE)) begin
                            pres_d  = ~dq_s2_q;
                            error_d = dq_s2_q;
                        end
                        if (cnt_us_q == US_W'(T_INIT_SLOT - 1)) begin
                            cnt_us_d   = '0;
                            byte_idx_d = 1'b0;
                            bit_idx_d  = 3'd0;
                            if (pres_q) state_d = ST_WR_BYTE;
                            else        phase_d = 1'b0;
                        end
                    end
                    ST_WR_BYTE, ST_RD_BYTE: begin
                        if (state_q == ST_RD_BYTE && cnt_us_q == US_W'(T_RD_SAMPLE))
                            temp_raw_d[{byte_idx_q, bit_idx_q}] = dq_s2_q;
                        if (slot_last) begin
                            cnt_us_d  = '0;
                            bit_idx_d = bit_idx_q + 3'd1;
                            if (bit_idx_q == 3'd7) begin
                                byte_idx_d = ~byte_idx_q;
                                if (byte_idx_q) begin
                                    if (state_q == ST_RD_BYTE) state_d = ST_UPDATE;
                                    else state_d = phase_q ? ST_RD_BYTE : ST_CONV_WAIT;
                                end
                            end
                        end
                    end
                    ST_CONV_WAIT: begin
                        if (cnt_us_q == US_W'(CONV_US - 1)) begin
                            cnt_us_d = '0;
                            state_d  = ST_INIT;
                            phase_d  = 1'b1;
                        end
                    end
                    default: begin
                        state_d  = ST_INIT;
                        cnt_us_d = '0;
                    end
                endcase
            end

            cmd_d  = cmd_byte(phase_d, byte_idx_d);
            wr_bit = cmd_d[bit_idx_d];
            case (state_d)
                ST_INIT:    dq_oe_d = (cnt_us_d < US_W'(T_INIT_LOW));
                ST_WR_BYTE: dq_oe_d = (cnt_us_d < US_W'(T_SLOT_LOW)) ||
                                      (!wr_bit && (cnt_us_d < US_W'(T_WR0_LOW)));
                ST_RD_BYTE: dq_oe_d = (cnt_us_d < US_W'(T_SLOT_LOW));
                default:    dq_oe_d = 1'b0;
            endcase
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q    <= ST_INIT;
            cnt_div_q  <= '0;
            cnt_us_q   <= '0;
            phase_q    <= 1'b0;
            byte_idx_q <= 1'b0;
            bit_idx_q  <= 3'd0;
            run_q      <= 1'b0;
            pres_q     <= 1'b0;
            dq_oe_q    <= 1'b0;
            dq_s1_q    <= 1'b1;
            dq_s2_q    <= 1'b1;
            temp_raw_q <= 16'd0;
            data_q     <= 20'd0;
            point_q    <= 6'd0;
            sign_q     <= 1'b0;
            seg_en_q   <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_div_q  <= cnt_div_d;
            cnt_us_q   <= cnt_us_d;
            phase_q    <= phase_d;
            byte_idx_q <= byte_idx_d;
            bit_idx_q  <= bit_idx_d;
            run_q      <= run_d;
            pres_q     <= pres_d;
            dq_oe_q    <= dq_oe_d;
            dq_s1_q    <= dq;
            dq_s2_q    <= dq_s1_q;
            temp_raw_q <= temp_raw_d;
            data_q     <= data_d;
            point_q    <= point_d;
            sign_q     <= sign_d;
            seg_en_q   <= seg_en_d;
            error_q    <= error_d;
        end
    end

endmodule

// File: tb/tb_ds18b20_ctrl.sv
// Bench for ds18b20_ctrl: a DS18B20 sensor model that also decodes and
// times every bus slot, plus a millidegree reference computed from degrees.
`timescale 1ns/1ps
module tb_ds18b20_ctrl;
    localparam int CLK_DIV = 2;
    localparam int CONV_US = 100;
    localparam int US_NS   = 10 * CLK_DIV;

    // clock / reset
    logic sys_clk = 1'b0;
    logic sys_rst_n = 1'b0;
    always #5 sys_clk = ~sys_clk;

    wire         dq;
    logic [19:0] data;
    logic [5:0]  point;
    logic        sign;
    logic        seg_en;
    logic        error;
    logic [2:0]  dbg_state;

    logic sensor_low = 1'b0;
    pullup (dq);
    assign dq = sensor_low ? 1'b0 : 1'bz;

    ds18b20_ctrl #(.CLK_DIV(CLK_DIV), .CONV_US(CONV_US)) dut (
        .sys_clk     (sys_clk),
        .sys_rst_n   (sys_rst_n),
        .dq          (dq),
        .data        (data),
        .point       (point),
        .sign        (sign),
        .seg_en      (seg_en),
        .error       (error),
        .dbg_state_o (dbg_state)
    );

    int checks = 0;
    int failures = 0;
    logic [20:0] exp_q[$];

    logic        sensor_present = 1'b1;
    logic [15:0] scratch = 16'd0;
    int          mon_inits = 0;
    int          mon_reads = 0;
    logic        expect_read = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Reference: sixteenths of a degree -> millidegrees, sign kept apart.
    function automatic logic [20:0] model_mdeg(input logic [15:0] raw);
        int t;
        int m;
        t = int'($signed(raw));
        m = (t < 0) ? -t : t;
        return {(t < 0), 20'((m * 1000) / 16)};
    endfunction

    // driver tasks
    task automatic wait_us(input int n);
        repeat (n * CLK_DIV) @(negedge sys_clk);
    endtask

    task automatic wait_inits(input int target, input int budget_us);
        int c = 0;
        while (mon_inits < target && c < budget_us * CLK_DIV) begin
            @(negedge sys_clk);
            c++;
        end
        check("wait_init_pulse", (mon_inits >= target), 1);
    endtask

    task automatic wait_reads(input int target, input int budget_us);
        int c = 0;
        while (mon_reads < target && c < budget_us * CLK_DIV) begin
            @(negedge sys_clk);
            c++;
        end
        check("wait_read_seq", (mon_reads >= target), 1);
    endtask

    task automatic check_reading(output logic [19:0] d, output logic s);
        logic [20:0] e;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 21'd0;
        check("data", data, e[19:0]);
        check("sign", sign, e[20]);
        check("point", point, 6'b001000);
        check("seg_en", seg_en, 1);
        check("error_clear", error, 0);
        d = e[19:0];
        s = e[20];
    endtask

    // sensor model + bus monitor
    initial begin : monitor
        time  t0;
        int   w;
        int   nbits;
        logic reading;
        logic bitv;
        logic [15:0] rx;
        nbits = 0;
        reading = 1'b0;
        rx = 16'd0;
        forever begin
            @(negedge dq);
            t0 = $time;
            if (reading) begin
                if (scratch[nbits - 16] == 1'b0) begin
                    sensor_low = 1'b1;
                    #(30 * US_NS);
                    sensor_low = 1'b0;
                    #1;
                end else begin
                    @(posedge dq);
                end
                nbits++;
                if (nbits == 32) begin
                    reading = 1'b0;
                    mon_reads++;
                end
            end else begin
                @(posedge dq);
                w = int'(($time - t0) / US_NS);
                if (!sys_rst_n) begin
                    nbits = 0;
                    expect_read = 1'b0;
                end else if (w >= 480) begin
                    check("init_low_us", w, 500);
                    nbits = 0;
                    mon_inits++;
                    if (sensor_present) begin
                        #(30 * US_NS);
                        sensor_low = 1'b1;
                        #(120 * US_NS);
                        sensor_low = 1'b0;
                        #1;
                    end else begin
                        expect_read = 1'b0;
                    end
                end else begin
                    bitv = (w < 15);
                    check(bitv ? "wr1_low_us" : "wr0_low_us", w, bitv ? 2 : 60);
                    rx = {bitv, rx[15:1]};
                    nbits++;
                    if (nbits == 16) begin
                        check("cmd_skip_rom", rx[7:0], 8'hCC);
                        check("cmd_function", rx[15:8], expect_read ? 8'hBE : 8'h44);
                        if (rx[15:8] == 8'hBE) begin
                            reading = 1'b1;
                            expect_read = 1'b0;
                        end else begin
                            expect_read = 1'b1;
                        end
                    end
                end
            end
        end
    end

    initial begin : main
        logic [15:0] vals [5];
        logic [19:0] last_data;
        logic        last_sign;
        logic [15:0] rnd_raw;
        int          r;
        int          n;
        vals = '{16'h0191, 16'hFF5E, 16'h07D0, 16'hFC90, 16'h0000};

        repeat (5) @(negedge sys_clk);
        check("rst_data", data, 0);
        check("rst_point", point, 0);
        check("rst_sign", sign, 0);
        check("rst_seg_en", seg_en, 0);
        check("rst_error", error, 0);
        check("rst_dq", dq, 1);
        last_data = 20'd0;
        last_sign = 1'b0;
        sys_rst_n = 1'b1;

        for (int i = 0; i < 5; i++) begin
            scratch = vals[i];
            exp_q.push_back(model_mdeg(vals[i]));
            wait_reads(i + 1, 7000);
            check("hold_before_update", data, last_data);
            wait_us(80);
            check_reading(last_data, last_sign);
        end

        // absent sensor during the read-phase INIT
        n = 0;
        while (!expect_read && n < 3000 * CLK_DIV) begin
            @(negedge sys_clk);
            n++;
        end
        check("convert_pair_seen", expect_read, 1);
        sensor_present = 1'b0;
        n = mon_inits;
        wait_inits(n + 1, 1500);
        wait_us(100);
        check("nopres_error", error, 1);
        check("nopres_data_held", data, last_data);
        check("nopres_sign_held", sign, last_sign);
        check("nopres_seg_en", seg_en, 1);
        sensor_present = 1'b1;
        wait_inits(n + 2, 1200);
        check("error_sticky", error, 1);
        wait_us(100);
        check("error_cleared", error, 0);

        r = int'($urandom_range(2880, 0)) - 880;
        if (r == 0) r = 1;
        rnd_raw = 16'(r);
        scratch = rnd_raw;
        exp_q.push_back(model_mdeg(rnd_raw));
        wait_reads(6, 7000);
        check("hold_before_update", data, last_data);
        wait_us(80);
        check_reading(last_data, last_sign);

        // reset in the middle of the first write-0 slot
        n = mon_inits;
        wait_inits(n + 1, 1500);
        wait_us(530);
        check("pre_reset_dq_low", dq, 0);
        sys_rst_n = 1'b0;
        #1;
        check("reset_dq_released", dq, 1);
        check("reset_data", data, 0);
        check("reset_point", point, 0);
        check("reset_sign", sign, 0);
        check("reset_seg_en", seg_en, 0);
        check("reset_error", error, 0);
        repeat (4) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        n = mon_inits;
        wait_inits(n + 1, 1500);
        wait_us(10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ds18b20_ctrl.md
# ds18b20_ctrl

DS18B20 one-wire master that periodically triggers a temperature conversion, reads back the 16-bit result and converts it to sign-magnitude millidegrees. Sits directly upstream of the six-digit dynamic seven-segment driver. Its `data`, `point`, `sign` and `seg_en` outputs connect straight to that driver's inputs.

## Interface
- `CLK_DIV`, 50: sys_clk cycles per 1 µs tick.
- `CONV_US`, 750_000: conversion wait in µs; benches shorten it.
- `sys_clk` in 1: system clock, 50 MHz.
- `sys_rst_n` in 1: reset, asynchronous assert, active low.
- `dq` inout 1: one-wire bus, open drain. Block drives `1'b0` or `1'bz` only; external pull-up.
- `data` out 20: |T| in 0.001 °C units.
- `point` out 6: decimal-point mask for the display.
- `sign` out 1: 1 means negative temperature.
- `seg_en` out 1: display enable; high once the first valid reading is published.
- `error` out 1: last reset pulse saw no presence. Sticky until the next successful presence.

## Operation
- **Time base.** `cnt_div` counts 0..CLK_DIV-1. `tick` pulses for one cycle on the wrap. All bus timing below is in ticks (µs), counted by `cnt_us`.
- **FSM states.** INIT, WR_BYTE, CONV_WAIT, RD_BYTE, UPDATE.
  - `phase` bit: 0 = convert sequence, 1 = read sequence.
  - `byte_idx` 0..1 and `bit_idx` 0..7 (LSB first).
- **Convert sequence (phase 0).**
  - INIT.
  - WR_BYTE 0xCC (skip ROM), then WR_BYTE 0x44 (convert).
  - CONV_WAIT for CONV_US.
  - INIT with phase 1.
- **Read sequence (phase 1).**
  - INIT.
  - WR_BYTE 0xCC, then WR_BYTE 0xBE (read scratchpad).
  - RD_BYTE ×2: LSB byte, then MSB byte, into `temp_raw[15:0]`.
  - UPDATE, then INIT with phase 0.
- **INIT slot (1000 µs).**
  - Drive low for µs 0–499, then release.
  - Sample `dq` at µs 570: 0 means presence.
  - No presence: set `error`, skip the remaining steps and restart INIT with phase 0 after µs 999. Outputs are held.
  - Presence: clear `error` and continue.
- **Write slot (64 µs).**
  - Drive low µs 0–1.
  - Bit 1: release from µs 2.
  - Bit 0: hold low through µs 59, release µs 60–63.
- **Read slot (64 µs).**
  - Drive low µs 0–1, release.
  - Sample `dq` at µs 13 into `temp_raw[8*byte_idx+bit_idx]`. Idle to µs 63.
- **UPDATE (one cycle), arithmetic.**
  - neg = `temp_raw[15]`.
  - mag = neg ? (~temp_raw + 1) : temp_raw, truncated to 11 bits.
  - `data` <= (mag × 125) >> 1, truncating, in 20 bits. Max 2000 → 125000.
  - `sign` <= neg.
  - `point` <= 6'b001000.
  - `seg_en` <= 1.
- Outputs change only in UPDATE and hold otherwise.

## Timing
- **Reset values.**
  - `data` 0, `point` 0, `sign` 0, `seg_en` 0, `error` 0.
  - `dq` released (z), FSM in INIT with phase 0, all counters 0.
- Reset asserted mid-slot releases `dq` asynchronously. After deassertion the block starts a fresh INIT on the first tick.
- **Latency.**
  - Outputs update the cycle after the sample of MSB bit 7 plus slot completion, i.e. at the end of slot 16 of RD_BYTE.
  - Full period ≈ 2×1000 + 4×8×64 + 16×64 + CONV_US µs.
- `dq` is sampled through a 2-flop synchronizer. Sample points refer to the synchronized value, with a fixed 2-cycle skew that is acceptable.
- Slot boundaries coincide with `tick`. `cnt_us` clears on every state or slot change.
- `error` and outputs never change in the same cycle as each other; only one of the two can apply per INIT.

## Structure
- Shared package `ds18b20_pkg`:
  - State enum.
  - Command constants CMD_SKIP_ROM=8'hCC, CMD_CONVERT=8'h44, CMD_READ=8'hBE.
  - Slot timing constants (500, 570, 1000, 64, 60, 13).
  - POINT_MDEG=6'b001000.
- One sub-module, `ds18b20_temp_fmt`: combinational two's-complement → magnitude ×125 >>1 conversion, registered in UPDATE.

## Test plan
- **Positive reading.** Sensor model with presence, scratchpad 0x0191 → `data`=25062, `sign`=0, `point`=6'b001000, `seg_en`=1 after the first read.
- **Negative reading.** Scratchpad 0xFF5E (−10.125 °C) → `data`=10125, `sign`=1.
- **Extremes.**
  - 0x07D0 → 125000.
  - 0xFC90 (−55 °C) → 55000, `sign`=1.
  - 0x0000 → 0, `sign`=0.
- **No presence.** Model never pulls low → `error`=1 at µs 570, outputs unchanged, INIT retries. Presence restored → `error`=0 and the next read publishes.
- **Bus monitor.**
  - Decodes write slots as 0xCC,0x44 then 0xCC,0xBE, LSB first.
  - Checks low widths: 2 µs for a 1, 60 µs for a 0.
  - Checks INIT low width of 500 µs.
- **Reset mid-operation.** Assert `sys_rst_n` during a write-0 low period → `dq` goes z immediately and all outputs return to reset values. After release a new 500 µs INIT starts.
